// File: rtl/dmem_byte_ram_if.sv
// Request/response bus between the load/store stage and dmem_byte_ram.
// The master drives requests; the slave (the RAM) drives responses and status.
interface dmem_byte_ram_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  init_busy;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// Byte-addressable RV32I data RAM with 1-cycle responses and a post-reset clear engine.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_byte_ram #(
  parameter int unsigned                ADDR_WIDTH  = 32,
  parameter int unsigned                DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = '0
) (
  input logic             clk,
  input logic             reset_n,
  dmem_byte_ram_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] ByteSpan = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          st_q;
  logic [IdxW-1:0] cnt_q;
  logic            ready_q, busy_q;

  // Response pipeline state
  logic            valid_q, we_q, err_q;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic [31:0]     rd_word_q;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] offset;
  logic [IdxW-1:0]       idx, wr_idx;
  logic [1:0]            lane, lane_eff;
  logic                  in_range, bad_f3, misalign, err, accept;
  logic                  is_half, is_word;
  logic [3:0]            store_be, wr_be;
  logic [31:0]           store_data, wr_data;

  assign accept = bus.req_valid && ready_q;

  always_comb begin
    offset   = bus.req_addr - BASE_ADDR;
    in_range = {1'b0, offset} < ByteSpan;
    idx      = offset[IdxW+1:2];
    lane     = offset[1:0];
    is_half  = bus.req_funct3[1:0] == 2'b01;
    is_word  = bus.req_funct3[1:0] == 2'b10;
    // Size 11 is never legal; bit 2 only exists on LBU/LHU loads.
    bad_f3   = (bus.req_funct3[1:0] == 2'b11) ||
               (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    lane_eff = lane;
`else
    misalign = 1'b0;
    lane_eff = is_word ? 2'b00 : (is_half ? {lane[1], 1'b0} : lane);
`endif
    err = bad_f3 || !in_range || misalign;

    if (is_word) begin
      store_be   = 4'b1111;
      store_data = bus.req_wdata;
    end else if (is_half) begin
      store_be   = lane_eff[1] ? 4'b1100 : 4'b0011;
      store_data = {2{bus.req_wdata[15:0]}};
    end else begin
      store_be   = 4'b0001 << lane_eff;
      store_data = {4{bus.req_wdata[7:0]}};
    end
  end

  // Single write port shared by the clear engine and stores.
  always_comb begin
    wr_be   = '0;
    wr_idx  = idx;
    wr_data = store_data;
    if (st_q == StInit) begin
      wr_be   = 4'b1111;
      wr_idx  = cnt_q;
      wr_data = '0;
    end else if (accept && bus.req_we && !err) begin
      wr_be = store_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_idx][b] <= wr_data[8*b +: 8];
    end
    if (accept) rd_word_q <= mem[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= StInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (st_q)
        StInit: begin
          if (cnt_q == LastIdx) begin
            st_q    <= StRun;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: ;
        default: st_q <= StInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        we_q   <= bus.req_we;
        err_q  <= err;
        f3_q   <= bus.req_funct3;
        lane_q <= lane_eff;
      end
    end
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  always_comb begin
    unique case (lane_q)
      2'd0: sel_byte = rd_word_q[7:0];
      2'd1: sel_byte = rd_word_q[15:8];
      2'd2: sel_byte = rd_word_q[23:16];
      default: sel_byte = rd_word_q[31:24];
    endcase
    sel_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    unique case (f3_q[1:0])
      2'b00:   load_data = {{24{sel_byte[7] & ~f3_q[2]}}, sel_byte};
      2'b01:   load_data = {{16{sel_half[15] & ~f3_q[2]}}, sel_half};
      default: load_data = rd_word_q;
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.init_busy = busy_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_err   = valid_q && err_q;
  assign bus.rsp_rdata = (valid_q && !we_q && !err_q) ? load_data : 32'h0;
endmodule

// File: tb/tb_dmem_byte_ram.sv
// Directed bench for dmem_byte_ram: clear engine, sub-word access, pipelining, errors, reset.
module tb_dmem_byte_ram;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dmem_byte_ram_if #(.ADDR_WIDTH(32)) bus ();

  dmem_byte_ram #(
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(256),
    .BASE_ADDR  (32'h0)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One request, then check its response at the following negedge.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, ".valid"}, 32'(bus.rsp_valid), 32'h1);
    check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
  endtask

  // Called at the negedge where reset_n is released.
  task automatic wait_init(input string tag);
    int n = 0;
    while (bus.init_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".init_cycles"}, 32'(n), 32'd256);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.req_wdata  = '0;

    repeat (3) @(negedge clk);
    check("rst.ready", 32'(bus.req_ready), 32'h0);
    check("rst.busy", 32'(bus.init_busy), 32'h1);
    check("rst.valid", 32'(bus.rsp_valid), 32'h0);
    check("rst.rdata", bus.rsp_rdata, 32'h0);
    check("rst.err", 32'(bus.rsp_err), 32'h0);
    reset_n = 1'b1;
    wait_init("init0");

    // Preload, then reset and confirm the clear.
    xact("pre_sw0", 1'b1, 32'h0, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("pre_sw3fc", 1'b1, 32'h3FC, 3'b010, 32'h12345678, 32'h0, 1'b0);
    xact("pre_lw0", 1'b0, 32'h0, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_init("init1");
    xact("clr_lw0", 1'b0, 32'h0, 3'b010, 32'h0, 32'h0, 1'b0);
    xact("clr_lw3fc", 1'b0, 32'h3FC, 3'b010, 32'h0, 32'h0, 1'b0);

    // Sub-word stores and loads
    xact("sw10", 1'b1, 32'h10, 3'b010, 32'h11223344, 32'h0, 1'b0);
    xact("sb11", 1'b1, 32'h11, 3'b000, 32'h000000AB, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 3'b010, 32'h0, 32'h1122AB44, 1'b0);
    xact("lb11", 1'b0, 32'h11, 3'b000, 32'h0, 32'hFFFFFFAB, 1'b0);
    xact("lbu11", 1'b0, 32'h11, 3'b100, 32'h0, 32'h000000AB, 1'b0);
    xact("lh12", 1'b0, 32'h12, 3'b001, 32'h0, 32'h00001122, 1'b0);
    xact("lh10", 1'b0, 32'h10, 3'b001, 32'h0, 32'hFFFFAB44, 1'b0);
    xact("lhu10", 1'b0, 32'h10, 3'b101, 32'h0, 32'h0000AB44, 1'b0);
    xact("sh16", 1'b1, 32'h16, 3'b001, 32'hFFFF8001, 32'h0, 1'b0);
    xact("lw14", 1'b0, 32'h14, 3'b010, 32'h0, 32'h80010000, 1'b0);

    // Back-to-back store then load of the same word
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_funct3 = 3'b010;
    bus.req_wdata  = 32'hDEADBEEF;
    @(negedge clk);
    check("pipe.st_valid", 32'(bus.rsp_valid), 32'h1);
    check("pipe.st_rdata", bus.rsp_rdata, 32'h0);
    bus.req_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("pipe.ld_valid", 32'(bus.rsp_valid), 32'h1);
    check("pipe.ld_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("pipe.idle_valid", 32'(bus.rsp_valid), 32'h0);

    // Errors
    xact("lw400", 1'b0, 32'h400, 3'b010, 32'h0, 32'h0, 1'b1);
    xact("ld_f3_011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    xact("ld_f3_110", 1'b0, 32'h10, 3'b110, 32'h0, 32'h0, 1'b1);
    xact("sw400", 1'b1, 32'h400, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("lw0_after_sw400", 1'b0, 32'h0, 3'b010, 32'h0, 32'h0, 1'b0);
    xact("st_f3_100", 1'b1, 32'h20, 3'b100, 32'h00000055, 32'h0, 1'b1);
    xact("lw20_unchanged", 1'b0, 32'h20, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Misalignment
`ifdef DMEM_MISALIGN_CHECK_EN
    xact("lh13", 1'b0, 32'h13, 3'b001, 32'h0, 32'h0, 1'b1);
    xact("lw11", 1'b0, 32'h11, 3'b010, 32'h0, 32'h0, 1'b1);
    xact("sw21", 1'b1, 32'h21, 3'b010, 32'h0, 32'h0, 1'b1);
    xact("lw20_after_sw21", 1'b0, 32'h20, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
`else
    xact("lh13", 1'b0, 32'h13, 3'b001, 32'h0, 32'h00001122, 1'b0);
    xact("lw11", 1'b0, 32'h11, 3'b010, 32'h0, 32'h1122AB44, 1'b0);
    xact("sw21", 1'b1, 32'h21, 3'b010, 32'h01020304, 32'h0, 1'b0);
    xact("lw20_after_sw21", 1'b0, 32'h20, 3'b010, 32'h0, 32'h01020304, 1'b0);
`endif

    // Reset while a response is pending
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("midrst.valid_before", 32'(bus.rsp_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst.valid_after", 32'(bus.rsp_valid), 32'h0);
    check("midrst.busy", 32'(bus.init_busy), 32'h1);
    check("midrst.ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_init("init2");
    xact("midrst.lw10", 1'b0, 32'h10, 3'b010, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
